voting_machine_param: RTL and testbench

VOTING_MACHINE_PARAM -- requirements
Module: voting_machine_param

---
 rtl/voting_machine_param.sv | 161 ++++++++++++++++
 tb/tb_voting_machine_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/voting_machine_param.sv
// ---------------------------------------------------------------------------
// voting_machine_param: edge-detected vote tally, serial winner scan, results.
// Rev 1.0 | optional voter lockout: define VM_VOTER_LOCKOUT_EN
// ---------------------------------------------------------------------------
`default_nettype none

module voting_machine_param #(
  parameter int N_CAND = 3,
  parameter int CNT_W  = 6,
  parameter int IDX_W  = (N_CAND > 2) ? $clog2(N_CAND) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CAND-1:0]         i_vote,
  input  logic                      i_voting_over,
  input  logic                      i_next_voter,
  output logic [N_CAND*CNT_W-1:0]   o_count,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_done,
  output logic                      o_reject
);

  localparam logic [N_CAND-1:0] C_ONE   = N_CAND'(1);
  localparam logic [IDX_W-1:0]  C_LAST  = IDX_W'(N_CAND - 1);

  typedef enum logic [1:0] {
    VOTING = 2'd0,
    SCAN   = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_CAND-1:0] vote_q;
  logic              primed;
  logic [CNT_W-1:0]  tally [N_CAND];
  logic [N_CAND-1:0] sat;
  logic [N_CAND-1:0] edges;
  logic [N_CAND-1:0] inc;
  logic              single;
  logic              multi;
  logic              hit_sat;
  logic              accept;
  logic              reject_nxt;

  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  best_idx;
  logic [CNT_W-1:0]  best_cnt;
  logic [CNT_W-1:0]  cur_cnt;
  logic              tie_r;

  // Edges are masked until the first post-reset cycle has sampled the buttons.
  assign edges   = (state == VOTING && primed) ? (i_vote & ~vote_q) : '0;
  assign single  = (edges != '0) && ((edges & (edges - C_ONE)) == '0);
  assign multi   = (edges != '0) && !single;
  assign hit_sat = |(edges & sat);

  generate
    for (genvar k = 0; k < N_CAND; k++) begin : g_sat
      assign sat[k] = &tally[k];
    end
  endgenerate

`ifdef VM_VOTER_LOCKOUT_EN
  logic locked;

  assign accept = single && !hit_sat && !locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (state == VOTING) begin
      if (accept)            locked <= 1'b1;
      else if (i_next_voter) locked <= 1'b0;
    end
  end
`else
  logic unused_next_voter;

  assign unused_next_voter = i_next_voter;
  assign accept            = single && !hit_sat;
`endif

  assign reject_nxt = multi || (single && !accept);
  assign inc        = accept ? edges : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q   <= '0;
      primed   <= 1'b0;
      o_reject <= 1'b0;
      for (int k = 0; k < N_CAND; k++) tally[k] <= '0;
    end else begin
      vote_q   <= i_vote;
      primed   <= 1'b1;
      o_reject <= reject_nxt;
      for (int k = 0; k < N_CAND; k++) begin
        if (inc[k]) tally[k] <= tally[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cur_cnt = '0;
    for (int k = 0; k < N_CAND; k++) begin
      if (scan_idx == IDX_W'(k)) cur_cnt = tally[k];
    end
  end

  // Strict '>' keeps the lower index on equal tallies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      tie_r    <= 1'b0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + IDX_W'(1);
      if (scan_idx == '0) begin
        best_cnt <= cur_cnt;
        best_idx <= '0;
        tie_r    <= 1'b0;
      end else if (cur_cnt > best_cnt) begin
        best_cnt <= cur_cnt;
        best_idx <= scan_idx;
        tie_r    <= 1'b0;
      end else if (cur_cnt == best_cnt) begin
        tie_r    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= VOTING;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      VOTING:  if (i_voting_over) state_nxt = SCAN;
      SCAN:    if (scan_idx == C_LAST) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = VOTING;
    endcase
  end

  assign o_done   = (state == DONE);
  assign o_winner = o_done ? best_idx : '0;
  assign o_tie    = o_done && tie_r;

  generate
    for (genvar k = 0; k < N_CAND; k++) begin : g_flat
      assign o_count[k*CNT_W +: CNT_W] = o_done ? tally[k] : '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_voting_machine_param.sv
// Directed testbench for voting_machine_param (default build and CNT_W=2 instance).
`default_nettype none

module tb_voting_machine_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vote = '0;
  logic        over = 1'b0;
  logic        nv = 1'b0;
  logic [17:0] count;
  logic [1:0]  winner;
  logic        tie, done, reject;

  logic [2:0]  vote2 = '0;
  logic        over2 = 1'b0;
  logic        nv2 = 1'b0;
  logic [5:0]  count2;
  logic [1:0]  winner2;
  logic        tie2, done2, reject2;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic rej_seen;

  always #5 clk = ~clk;

  voting_machine_param dut (
    .clk(clk), .rst(rst), .i_vote(vote), .i_voting_over(over), .i_next_voter(nv),
    .o_count(count), .o_winner(winner), .o_tie(tie), .o_done(done), .o_reject(reject)
  );

  voting_machine_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_vote(vote2), .i_voting_over(over2), .i_next_voter(nv2),
    .o_count(count2), .o_winner(winner2), .o_tie(tie2), .o_done(done2), .o_reject(reject2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input int k);
    @(negedge clk) begin vote = '0; vote[k] = 1'b1; end
    @(negedge clk) vote = '0;
  endtask

  task automatic press2(input int k);
    @(negedge clk) begin vote2 = '0; vote2[k] = 1'b1; end
    @(negedge clk) vote2 = '0;
  endtask

  task automatic finish_vote();
    @(negedge clk) over = 1'b1;
    repeat (4) @(negedge clk);
    over = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done",   done,   0);
    check("rst_count",  count,  0);
    check("rst_winner", winner, 0);
    check("rst_tie",    tie,    0);
    check("rst_reject", reject, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reference sequence 0,1,0,2,1,1,0,2 with cycle-exact scan length
    rej_seen = 1'b0;
    press(0); rej_seen |= reject;
    press(1); rej_seen |= reject;
    press(0); rej_seen |= reject;
    press(2); rej_seen |= reject;
    press(1); rej_seen |= reject;
    press(1); rej_seen |= reject;
    press(0); rej_seen |= reject;
    press(2); rej_seen |= reject;
    check("seq_no_reject", rej_seen, 0);
    check("voting_count_hidden", count, 0);
    @(negedge clk) over = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk) check("scan_not_done", done, 0);
    @(negedge clk) check("scan_done", done, 1);
    over = 1'b0;
    check("seq_count",  count,  {6'd2, 6'd3, 6'd3});
    check("seq_winner", winner, 0);
    check("seq_tie",    tie,    1);

    // Reset while in DONE clears outputs immediately
    rst = 1'b1;
    #1;
    check("async_rst_done",  done,  0);
    check("async_rst_count", count, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Held button counts once
    @(negedge clk) vote = 3'b010;
    repeat (10) @(negedge clk);
    vote = '0;
    finish_vote();
    check("hold_count",  count,  {6'd0, 6'd1, 6'd0});
    check("hold_winner", winner, 1);
    check("hold_tie",    tie,    0);

    // Simultaneous edges rejected
    do_reset();
    @(negedge clk) vote = 3'b101;
    @(negedge clk) vote = '0;
    check("multi_reject", reject, 1);
    @(negedge clk) check("multi_reject_pulse", reject, 0);
    finish_vote();
    check("multi_count",  count,  0);
    check("zero_winner",  winner, 0);
    check("zero_tie",     tie,    1);

    // Button held through reset release is not counted; later tie is cleared
    @(negedge clk) begin rst = 1'b1; vote = 3'b001; end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    vote = '0;
    @(negedge clk);
    press(1); press(0); press(2); press(2);
    finish_vote();
    check("prime_count",  count,  {6'd2, 6'd1, 6'd1});
    check("prime_winner", winner, 2);
    check("prime_tie",    tie,    0);
    press(0);
    check("done_ignore_reject", reject, 0);
    check("done_ignore_count",  count,  {6'd2, 6'd1, 6'd1});

    // Reset in the second scan cycle
    do_reset();
    press(1);
    @(negedge clk) over = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    over = 1'b0;
    #1;
    check("midscan_done",   done,   0);
    check("midscan_count",  count,  0);
    check("midscan_winner", winner, 0);
    check("midscan_reject", reject, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    press(2);
    finish_vote();
    check("midscan_revote_done",  done,   1);
    check("midscan_revote_count", count,  {6'd1, 6'd0, 6'd0});

    // Voter lockout / next-voter behaviour
    do_reset();
    press(0);
    press(1);
`ifdef VM_VOTER_LOCKOUT_EN
    check("lock_reject", reject, 1);
`else
    check("lock_reject", reject, 0);
`endif
    @(negedge clk) nv = 1'b1;
    @(negedge clk) nv = 1'b0;
    press(1);
    check("lock_after_next", reject, 0);
    finish_vote();
`ifdef VM_VOTER_LOCKOUT_EN
    check("lock_count",  count,  {6'd0, 6'd1, 6'd1});
    check("lock_winner", winner, 0);
`else
    check("lock_count",  count,  {6'd0, 6'd2, 6'd1});
    check("lock_winner", winner, 1);
`endif

    // Saturation with CNT_W=2
    do_reset();
    press2(0); check("sat_p1", reject2, 0);
    press2(0); check("sat_p2", reject2, 0);
    press2(0); check("sat_p3", reject2, 0);
    press2(0); check("sat_p4", reject2, 1);
    press2(0); check("sat_p5", reject2, 1);
    @(negedge clk) over2 = 1'b1;
    repeat (4) @(negedge clk);
    over2 = 1'b0;
    check("sat_done",   done2,   1);
    check("sat_count",  count2,  {2'd0, 2'd0, 2'd3});
    check("sat_winner", winner2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
